// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and reserved-op decode for alu_seq.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_NOR = 4'b0100,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_SRA = 4'b1010,
    OP_SGT = 4'b1011,
    OP_MUL = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } alu_state_e;

  // MUL is only a legal op when the multiplier is built in.
  function automatic logic is_reserved(input logic [3:0] op, input logic mul_en);
    logic r;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR,
      OP_SUB, OP_SLT, OP_SLL, OP_SRL, OP_SRA, OP_SGT: r = 1'b0;
      OP_MUL:  r = ~mul_en;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier; first partial product is formed on the start edge,
// done pulses the cycle after the WIDTH-th iteration. No backpressure: start is only issued when idle.
module alu_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] src_hi;
  logic [WIDTH-1:0] src_lo;
  logic [WIDTH-1:0] src_mc;
  logic [WIDTH:0]   sum;

  // cnt counts completed iterations; it parks at WIDTH for one cycle to flag completion.
  assign busy = (cnt != '0) && (cnt != CW'(WIDTH));
  assign done = (cnt == CW'(WIDTH));
  assign prod = {hi, lo};

  always_comb begin
    src_hi = start ? '0 : hi;
    src_lo = start ? b  : lo;
    src_mc = start ? a  : mcand;
    sum    = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mc} : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (start) begin
      mcand <= a;
      hi    <= sum[WIDTH:1];
      lo    <= {sum[0], src_lo[WIDTH-1:1]};
      cnt   <= CW'(1);
    end else if (busy) begin
      hi    <= sum[WIDTH:1];
      lo    <= {sum[0], src_lo[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
    end else if (done) begin
      cnt   <= '0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops valid the cycle after accept, MUL after WIDTH clocks.
// Result is held stable until out_ready; in_ready follows out_ready while a result is held.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             cout,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_state_e       state;
  alu_op_e          op_e;
  logic             reserved;
  logic             is_mul;
  logic             accept;
  logic             mul_busy;
  logic             mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_sum;
  logic [WIDTH-1:0] d_res;
  logic             d_cout;
  logic             d_ovf;

  assign op_e     = alu_op_e'(op);
  assign reserved = is_reserved(op, MUL_EN);
  assign is_mul   = (op_e == OP_MUL) && !reserved;
  assign in_ready = !mul_busy && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  assign out_valid = (state == HOLD);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    sh      = b[SHW-1:0];
    add_sum = {1'b0, a} + {1'b0, b};
    sub_sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    d_res   = '0;
    d_cout  = 1'b0;
    d_ovf   = 1'b0;
    case (op_e)
      OP_AND: d_res = a & b;
      OP_OR:  d_res = a | b;
      OP_XOR: d_res = a ^ b;
      OP_NOR: d_res = ~(a | b);
      OP_ADD: begin
        d_res  = add_sum[WIDTH-1:0];
        d_cout = add_sum[WIDTH];
        d_ovf  = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        d_res  = sub_sum[WIDTH-1:0];
        d_cout = sub_sum[WIDTH];
        d_ovf  = (a[MSB] != b[MSB]) && (sub_sum[MSB] != a[MSB]);
      end
      OP_SLT: d_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SGT: d_res = {{(WIDTH-1){1'b0}}, ($signed(b) < $signed(a))};
      OP_SLL: d_res = a << sh;
      OP_SRL: d_res = a >> sh;
      OP_SRA: d_res = $signed(a) >>> sh;
      default: d_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      res    <= '0;
      res_hi <= '0;
      cout   <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (is_mul) begin
              state <= BUSY;
            end else begin
              // Reserved codes fall to the zero default above, so only err and zero need gating.
              state  <= HOLD;
              res    <= d_res;
              res_hi <= '0;
              cout   <= d_cout;
              zero   <= !reserved && (d_res == '0);
              ovf    <= d_ovf;
              err    <= reserved;
            end
          end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (mul_done) begin
            state  <= HOLD;
            res    <= mul_prod[WIDTH-1:0];
            res_hi <= mul_prod[2*WIDTH-1:WIDTH];
            cout   <= |mul_prod[2*WIDTH-1:WIDTH];
            zero   <= (mul_prod[WIDTH-1:0] == '0);
            ovf    <= 1'b0;
            err    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8: vector table, random ops vs reference model, corner sequences.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_valid2 = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_ready2 = 1'b1;
  logic [3:0] op = 4'h0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       in_ready, out_valid, cout, zero, ovf, err;
  logic [7:0] res, res_hi;
  logic       in_ready2, out_valid2, cout2, zero2, ovf2, err2;
  logic [7:0] res2, res_hi2;

  logic [19:0] got, got2;
  assign got  = {res_hi, res, cout, zero, ovf, err};
  assign got2 = {res_hi2, res2, cout2, zero2, ovf2, err2};

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .res_hi(res_hi), .cout(cout), .zero(zero), .ovf(ovf), .err(err)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .op(op), .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready2),
    .res(res2), .res_hi(res_hi2), .cout(cout2), .zero(zero2), .ovf(ovf2), .err(err2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the op definitions; returns {res_hi,res,cout,zero,ovf,err}.
  function automatic logic [19:0] model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, sh, r, hi, p, s;
    logic c, v, e, z;
    ux = int'(x); uy = int'(y);
    sx = int'($signed(x)); sy = int'($signed(y));
    sh = uy % 8;
    r = 0; hi = 0; c = 0; v = 0; e = 0;
    case (o)
      4'd0:  r = ux & uy;
      4'd1:  r = ux | uy;
      4'd3:  r = ux ^ uy;
      4'd4:  r = ~(ux | uy);
      4'd2:  begin r = ux + uy; c = (r > 255); s = sx + sy; v = (s > 127) || (s < -128); end
      4'd6:  begin r = ux - uy; c = (ux >= uy); s = sx - sy; v = (s > 127) || (s < -128); end
      4'd7:  r = (sx < sy) ? 1 : 0;
      4'd11: r = (sy < sx) ? 1 : 0;
      4'd8:  r = ux << sh;
      4'd9:  r = ux >> sh;
      4'd10: r = sx >>> sh;
      4'd12: begin p = ux * uy; r = p; hi = p / 256; c = (hi != 0); end
      default: e = 1;
    endcase
    r  = r & 255;
    hi = hi & 255;
    z  = !e && (r == 0);
    return {hi[7:0], r[7:0], c, z, v, e};
  endfunction

  // Issue one op with out_ready=1 and wait for its result; lat counts edges after the accepting edge.
  task automatic run_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic [19:0] r, output int lat, output bit rdy_seen);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
    lat = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    r = got;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[15];
  logic [19:0] r;
  int lat, hits;
  bit rdy_seen;
  logic [3:0] ro;
  logic [7:0] ra, rb;

  initial begin
    //            op      a      b       res_hi res    c     z     v     e
    vecs[0]  = '{4'h2, 8'h7F, 8'h01, {8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = '{4'h6, 8'h05, 8'h05, {8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[2]  = '{4'h7, 8'hFD, 8'h02, {8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{4'hB, 8'hFD, 8'h02, {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[4]  = '{4'hC, 8'd20, 8'd13, {8'h01, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{4'hF, 8'h12, 8'h34, {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[6]  = '{4'hA, 8'h80, 8'h03, {8'h00, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{4'h1, 8'hF0, 8'h0F, {8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{4'h3, 8'hAA, 8'hFF, {8'h00, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{4'h4, 8'h00, 8'h00, {8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{4'h8, 8'h01, 8'hF7, {8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{4'h6, 8'h80, 8'h01, {8'h00, 8'h7F, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[12] = '{4'h6, 8'h00, 8'h01, {8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[13] = '{4'h2, 8'hFF, 8'h01, {8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[14] = '{4'hC, 8'hFF, 8'hFF, {8'hFE, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0}};

    // Reset state
    #1;
    chk("reset_outputs", {11'd0, out_valid, in_ready, got}, {11'd0, 1'b0, 1'b1, 20'h0});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // MUL on a build without the multiplier is a reserved op
    @(negedge clk);
    op = 4'hC; a = 8'd20; b = 8'd13; in_valid2 = 1'b1;
    @(posedge clk);
    #1 in_valid2 = 1'b0;
    @(negedge clk);
    chk("nomul_err", {11'd0, out_valid2, got2}, {11'd0, 1'b1, 8'h00, 8'h00, 4'b0001});

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, rdy_seen);
      chk($sformatf("vec%0d_result", i), {12'd0, r}, {12'd0, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), lat, (vecs[i].op == 4'hC) ? 8 : 0);
      if (vecs[i].op == 4'hC) chk($sformatf("vec%0d_in_ready_low", i), {31'd0, rdy_seen}, 32'd0);
    end

    for (int n = 0; n < 150; n++) begin
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ro, ra, rb, r, lat, rdy_seen);
      chk($sformatf("rand%0d_op%0h_%02h_%02h", n, ro, ra, rb), {12'd0, r}, {12'd0, model(ro, ra, rb)});
      chk($sformatf("rand%0d_latency", n), lat, (ro == 4'hC) ? 8 : 0);
    end

    // Backpressure: ADD held for 5 cycles, then back-to-back transfer with OR
    @(negedge clk);
    op = 4'h2; a = 8'h7F; b = 8'h01; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    op = 4'h6; a = 8'h33; b = 8'h44;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("hold_cycle%0d", c), {10'd0, out_valid, in_ready, got},
          {10'd0, 1'b1, 1'b0, 8'h00, 8'h80, 4'b0010});
    end
    @(negedge clk);
    out_ready = 1'b1; op = 4'h1; a = 8'hF0; b = 8'h0F; in_valid = 1'b1;
    #1;
    chk("hold_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("back_to_back_or", {11'd0, out_valid, got}, {11'd0, 1'b1, 8'h00, 8'hFF, 4'b0000});

    // Reset 3 cycles into a MUL: result discarded, nothing stale afterwards
    @(negedge clk);
    op = 4'hC; a = 8'd20; b = 8'd13; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_mul_reset", {11'd0, out_valid, in_ready, got[19:12] == 8'h00, got[11:0]},
        {11'd0, 1'b0, 1'b1, 1'b1, 12'h000});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) hits++;
    end
    chk("no_stale_result", hits, 0);
    run_op(4'h2, 8'h03, 8'h04, r, lat, rdy_seen);
    chk("post_reset_add", {12'd0, r}, {12'd0, 8'h00, 8'h07, 4'b0000});
    chk("post_reset_latency", lat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
